operand_loader: RTL
===================

// Module: operand_loader
// PURPOSE
//  Front-end writer for the 32-bit add/sub display path: turns board switches and two
//  raw push buttons into two 32-bit operands, one byte per press. Drives ord1/ord2,
//  the byte counter and the operand select consumed by the adder/display stage.
//  It sits between the board I/O pins and the add/sub datapath.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  cycles a synchronised button must hold a level before it is accepted
//  CNT_W            20      width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk        in   1   system clock, single clock domain
//  rst_n      in   1   asynchronous, active-low reset
//  sw         in   8   byte value to load, sampled on an accepted load press
//  btn_load   in   1   raw, bouncy, asynchronous load button (active-high)
//  btn_clr    in   1   raw, bouncy, asynchronous clear button (active-high)
//  ord1       out  32  operand 1 (first operand)
//  ord2       out  32  operand 2 (second operand)
//  counter    out  2   index of the next byte to be written (0 = LSB byte)
//  fstorsnd   out  1   operand currently being written: 0 = ord1, 1 = ord2
//  wr_pulse   out  1   one-cycle strobe in the cycle the byte register updates
//  done       out  1   high once all 8 bytes are loaded
// BEHAVIOUR
//  - Reset (async assert, sync release): ord1=0, ord2=0, counter=0, fstorsnd=0,
//    wr_pulse=0, done=0, state=LOAD_A, debounce counters and stable levels=0.
//  - Button path, per button: 2-flop synchroniser, then debounce. The stable level
//    changes only after the synchronised input differs from it for DEBOUNCE_CYCLES
//    consecutive cycles. A bounce resets the count. A 0->1 stable transition gives a
//    one-cycle press pulse. Release generates no event.
//  - FSM states and transitions:
//    LOAD_A: on load press, write sw into ord1[8*counter +: 8].
//      counter != 3: counter++.
//      counter == 3: counter=0, fstorsnd=1, go to LOAD_B.
//    LOAD_B: on load press, write sw into ord2[8*counter +: 8].
//      counter != 3: counter++.
//      counter == 3: counter=0, done=1, go to FULL.
//    FULL: load presses are ignored (no write, no wr_pulse). counter=0, fstorsnd=1.
//  - Clear press, from any state: ord1=ord2=0, counter=0, fstorsnd=0, done=0,
//    go to LOAD_A.
//  - Simultaneous clear and load press pulses in one cycle: clear wins, and the load
//    is dropped.
//  - Latency: the byte register, counter, fstorsnd, done and wr_pulse all update at
//    the clock edge after the press pulse. Press pulse to visible ord change is
//    1 cycle.
//  - Raw edge to ord change: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, +/-1 cycle.
//  - Holding a button produces exactly one press. The next press needs a debounced
//    release first.
//  - sw is sampled only in the write cycle. sw changes at other times have no effect.
//  - A reset in mid-debounce or mid-load discards all progress. No partial state
//    survives.
//  - All outputs are registered. No combinational path runs from inputs to outputs.
// STRUCTURE
//  - Shared header operand_defs.vh holds the state encodings (LOAD_A=2'd0,
//    LOAD_B=2'd1, FULL=2'd2) and the byte count constant (NBYTES=4). These are
//    shared with the add/sub datapath.
//  - Sub-module button_debounce(clk, rst_n, btn_raw, level, press) holds the
//    synchroniser, counter and edge pulse. It is instantiated twice (load, clear)
//    with DEBOUNCE_CYCLES and CNT_W passed down.
//  - The top level holds the FSM, counter, and the ord1/ord2 byte-enable registers.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4)
//  1. Reset: assert rst_n=0 mid-clock.
//     -> All outputs 0 immediately, with no clock edge needed.
//  2. Full load: 8 clean presses with sw = 11,22,33,44,55,66,77,88 (hex).
//     -> ord1=32'h44332211 and ord2=32'h88776655. done=1, fstorsnd=1, counter=0.
//     -> Exactly 8 wr_pulse.
//  3. Bounce: btn_load toggles every 2 cycles for 20 cycles, then holds 1.
//     -> Exactly one write, occurring 2+4+1 cycles after the final rise (+/-1).
//     -> No write during the bounce.
//  4. Overflow: a 9th press in FULL with sw=8'hFF.
//     -> ord1/ord2 unchanged, no wr_pulse, done stays 1.
//  5. Clear mid-operand: after 5 bytes, press clr.
//     -> ord1=ord2=0, counter=0, fstorsnd=0, done=0.
//     -> The next press writes ord1[7:0].
//  6. Collision: load and clr debounced on the same cycle.
//     -> Clear result as in test 5, and no byte written.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM encodings, byte count and
// the byte-lane insert helper used by the operand registers.
package operand_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } load_state_t;

  localparam int         NBYTES    = 4;
  localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

  // Returns word with byte lane idx replaced by b (lane 0 = LSB).
  function automatic logic [31:0] byte_insert(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    res[{idx, 3'b000} +: 8] = b;
    return res;
  endfunction

endpackage

// File: rtl/operand_loader_button_debounce.sv
// Two-flop synchroniser, persistence-count debouncer and rising press pulse
// for one raw push button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             expire_s;

  // Level change is accepted once the input has disagreed for the full window.
  always_comb begin
    differ_s = sync2_r ^ level_r;
    expire_s = differ_s && (cnt_r == LAST_CNT);
  end

  // Synchroniser, persistence counter, stable level and press strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      if (!differ_s || expire_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      level_r <= expire_s ? sync2_r : level_r;
      press_r <= expire_s & sync2_r;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/operand_loader.sv
// Builds two 32-bit operands one switch byte per debounced load press;
// a clear press restarts from the first operand.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic        btn_load,
  input  logic        btn_clr,
  output logic [31:0] ord1,
  output logic [31:0] ord2,
  output logic [1:0]  counter,
  output logic        fstorsnd,
  output logic        wr_pulse,
  output logic        done
);

  logic        load_press_s;
  logic        clr_press_s;
  logic        unused_load_level_s;
  logic        unused_clr_level_s;

  load_state_t state_r;
  load_state_t state_nxt_s;

  logic [31:0] ord1_r,     ord1_nxt_s;
  logic [31:0] ord2_r,     ord2_nxt_s;
  logic [1:0]  counter_r,  counter_nxt_s;
  logic        fstorsnd_r, fstorsnd_nxt_s;
  logic        wr_pulse_r, wr_pulse_nxt_s;
  logic        done_r,     done_nxt_s;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_load),
    .level  (unused_load_level_s),
    .press  (load_press_s)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_clr),
    .level  (unused_clr_level_s),
    .press  (clr_press_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear outranks a coincident load press.
  always_comb begin
    state_nxt_s = state_r;
    if (clr_press_s) begin
      state_nxt_s = LOAD_A;
    end else if (load_press_s) begin
      case (state_r)
        LOAD_A:  state_nxt_s = (counter_r == LAST_BYTE) ? LOAD_B : LOAD_A;
        LOAD_B:  state_nxt_s = (counter_r == LAST_BYTE) ? FULL : LOAD_B;
        FULL:    state_nxt_s = FULL;
        default: state_nxt_s = LOAD_A;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output logic: next values of the operand, index and status registers.
  always_comb begin
    ord1_nxt_s     = ord1_r;
    ord2_nxt_s     = ord2_r;
    counter_nxt_s  = counter_r;
    fstorsnd_nxt_s = fstorsnd_r;
    done_nxt_s     = done_r;
    wr_pulse_nxt_s = 1'b0;
    if (clr_press_s) begin
      ord1_nxt_s     = 32'h0000_0000;
      ord2_nxt_s     = 32'h0000_0000;
      counter_nxt_s  = 2'd0;
      fstorsnd_nxt_s = 1'b0;
      done_nxt_s     = 1'b0;
    end else if (load_press_s) begin
      case (state_r)
        LOAD_A: begin
          ord1_nxt_s     = byte_insert(ord1_r, counter_r, sw);
          wr_pulse_nxt_s = 1'b1;
          if (counter_r == LAST_BYTE) begin
            counter_nxt_s  = 2'd0;
            fstorsnd_nxt_s = 1'b1;
          end else begin
            counter_nxt_s  = counter_r + 2'd1;
          end
        end
        LOAD_B: begin
          ord2_nxt_s     = byte_insert(ord2_r, counter_r, sw);
          wr_pulse_nxt_s = 1'b1;
          if (counter_r == LAST_BYTE) begin
            counter_nxt_s = 2'd0;
            done_nxt_s    = 1'b1;
          end else begin
            counter_nxt_s = counter_r + 2'd1;
          end
        end
        FULL: begin
          counter_nxt_s  = 2'd0;
          fstorsnd_nxt_s = 1'b1;
        end
        default: begin
          counter_nxt_s  = 2'd0;
          fstorsnd_nxt_s = 1'b0;
          done_nxt_s     = 1'b0;
        end
      endcase
    end else begin
      wr_pulse_nxt_s = 1'b0;
    end
  end

  // Operand and status registers driving the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord1_r     <= 32'h0000_0000;
      ord2_r     <= 32'h0000_0000;
      counter_r  <= 2'd0;
      fstorsnd_r <= 1'b0;
      wr_pulse_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      ord1_r     <= ord1_nxt_s;
      ord2_r     <= ord2_nxt_s;
      counter_r  <= counter_nxt_s;
      fstorsnd_r <= fstorsnd_nxt_s;
      wr_pulse_r <= wr_pulse_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign ord1     = ord1_r;
  assign ord2     = ord2_r;
  assign counter  = counter_r;
  assign fstorsnd = fstorsnd_r;
  assign wr_pulse = wr_pulse_r;
  assign done     = done_r;

endmodule
